// File: rtl/motion_pkg.sv
// rtl/motion_pkg.sv - shared mode codes and FSM state encoding for motion_integrator_n
package motion_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SAT  = 2'b01;
  localparam logic [1:0] MODE_WRAP = 2'b10;
  localparam logic [1:0] MODE_CLR  = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACK  = 3'd1,
    REQ  = 3'd2,
    WAIT = 3'd3,
    UPD  = 3'd4,
    DONE = 3'd5
  } state_e;

endpackage

// File: rtl/motion_axis_step.sv
// rtl/motion_axis_step.sv - combinational single-axis position step with overflow policy
module motion_axis_step
  import motion_pkg::*;
#(
  parameter int W  = 8,
  parameter int VW = 4
) (
  input  logic [W-1:0]  pos,
  input  logic [VW-1:0] vel,
  input  logic [1:0]    mode,
  output logic [W-1:0]  next,
  output logic          ovf
);

  logic [W-1:0] ve;
  logic [W-1:0] s;

  assign ve  = W'($signed(vel));
  assign s   = pos + ve;
  assign ovf = (pos[W-1] == ve[W-1]) && (s[W-1] != pos[W-1]);

  // Pick the wrapped sum unless it overflowed; then apply the policy (11 behaves as hold)
  always_comb begin
    next = s;
    if (ovf) begin
      case (mode)
        MODE_SAT:  next = ve[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        MODE_WRAP: next = s;
        default:   next = pos;
      endcase
    end
  end

endmodule

// File: rtl/motion_integrator_n.sv
// rtl/motion_integrator_n.sv - N-axis position integrator; MOTION_OVF_FLAG_EN adds sticky ovf flags
module motion_integrator_n
  import motion_pkg::*;
#(
  parameter int N  = 2,
  parameter int W  = 8,
  parameter int VW = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N*VW-1:0] v,
  output logic            soc_v,
  input  logic [N-1:0]    eoc_v,
  input  logic [1:0]      mode,
  input  logic            soc_p,
  output logic            eoc_p,
  output logic [N*W-1:0]  pos
`ifdef MOTION_OVF_FLAG_EN
  ,
  output logic [N-1:0]    ovf
`endif
);

  state_e                  state_q, state_d;
  logic [1:0]              mode_q, mode_d;
  logic                    soc_v_q;
  logic                    eoc_p_q;
  logic [N-1:0][W-1:0]     pos_q;
  logic [N-1:0][W-1:0]     next_w;
  logic [N-1:0]            ovf_w;
  logic [N-1:0]            load_w;
  logic                    upd_w;
  logic                    hold_w;
  logic                    start_w;

  assign upd_w   = (state_q == UPD);
  assign hold_w  = (mode_q == MODE_HOLD) || (mode_q == MODE_CLR);
  assign start_w = (state_q == IDLE) && soc_p;

  // Handshake sequencing and mode capture at the start of each update
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: if (soc_p) begin
        state_d = ACK;
        mode_d  = mode;
      end
      ACK:  if (!soc_p) state_d = REQ;
      REQ:  if (eoc_v == '0) state_d = WAIT;
      WAIT: if (&eoc_v) state_d = UPD;
      UPD:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, latched mode and handshake outputs; outputs are registered decodes of the next state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= MODE_HOLD;
      soc_v_q <= 1'b0;
      eoc_p_q <= 1'b1;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      soc_v_q <= (state_d == REQ);
      eoc_p_q <= (state_d == IDLE);
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_axis
    motion_axis_step #(
      .W  (W),
      .VW (VW)
    ) u_step (
      .pos  (pos_q[i]),
      .vel  (v[i*VW +: VW]),
      .mode (mode_q),
      .next (next_w[i]),
      .ovf  (ovf_w[i])
    );
    // A held overflow skips the load so the axis keeps exactly its own value
    assign load_w[i] = upd_w && !(ovf_w[i] && hold_w);
  end

  // Position registers, all axes loaded on the same UPD edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pos_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (load_w[i]) pos_q[i] <= next_w[i];
      end
    end
  end

`ifdef MOTION_OVF_FLAG_EN
  logic [N-1:0] ovf_q;

  // Sticky overflow flags, cleared only when an update is started with mode 11
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ovf_q <= '0;
    end else if (start_w && (mode == MODE_CLR)) begin
      ovf_q <= '0;
    end else if (upd_w) begin
      ovf_q <= ovf_q | ovf_w;
    end
  end

  assign ovf = ovf_q;
`else
  logic unused_start;
  assign unused_start = start_w;
`endif

  assign soc_v = soc_v_q;
  assign eoc_p = eoc_p_q;
  assign pos   = pos_q;

endmodule

// File: tb/tb_motion_integrator_n.sv
// tb/tb_motion_integrator_n.sv - self-checking bench for motion_integrator_n (N=2, W=8, VW=4)
module tb_motion_integrator_n;

  logic        clock;
  logic        reset;
  logic [7:0]  v;
  logic        soc_v;
  logic [1:0]  eoc_v;
  logic [1:0]  mode;
  logic        soc_p;
  logic        eoc_p;
  logic [15:0] pos;
`ifdef MOTION_OVF_FLAG_EN
  logic [1:0]  ovf;
`endif

  int errors = 0;
  int checks = 0;

  logic [7:0] pm [2];
  logic [1:0] om;

  motion_integrator_n #(.N(2), .W(8), .VW(4)) dut (
    .clock (clock),
    .reset (reset),
    .v     (v),
    .soc_v (soc_v),
    .eoc_v (eoc_v),
    .mode  (mode),
    .soc_p (soc_p),
    .eoc_p (eoc_p),
    .pos   (pos)
`ifdef MOTION_OVF_FLAG_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] ref_next(input logic [7:0] p, input logic [3:0] vel,
                                          input logic [1:0] md, output bit o);
    int pi, vi, sum;
    logic [7:0] r;
    pi  = int'($signed(p));
    vi  = int'($signed(vel));
    sum = pi + vi;
    o   = (sum > 127) || (sum < -128);
    r   = 8'(sum);
    if (o) begin
      if (md == 2'b01) r = (sum > 127) ? 8'h7F : 8'h80;
      else if (md == 2'b10) r = 8'(sum);
      else r = p;
    end
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    soc_p = 1'b0;
    eoc_v = 2'b11;
    @(negedge clock);
    reset = 1'b0;
    pm[0] = 8'h00;
    pm[1] = 8'h00;
    om    = 2'b00;
  endtask

  task automatic run_update(input logic [3:0] vx, input logic [3:0] vy, input logic [1:0] md,
                            input bit stag, input string tag);
    logic [7:0]  ex, ey;
    logic [15:0] old;
    bit          ox, oy;
    int          n;
    ex  = ref_next(pm[0], vx, md, ox);
    ey  = ref_next(pm[1], vy, md, oy);
    old = {pm[1], pm[0]};
    if (md == 2'b11) om = 2'b00;
    om = om | {oy, ox};
    @(negedge clock);
    checks++;
    if (eoc_p !== 1'b1) begin errors++; $display("FAIL %s idle_eoc_p got=%b want=1", tag, eoc_p); end
    mode  = md;
    soc_p = 1'b1;
    @(negedge clock);
    soc_p = 1'b0;
    mode  = 2'($urandom);
    v     = 8'($urandom);
    n = 0;
    while (soc_v !== 1'b1 && n < 20) begin @(negedge clock); n++; end
    checks++;
    if (n >= 20) begin errors++; $display("FAIL %s soc_v_timeout got=%b want=1", tag, soc_v); return; end
    if (stag) begin
      eoc_v = 2'b10;
      @(negedge clock);
      checks++;
      if (soc_v !== 1'b1) begin errors++; $display("FAIL %s partial_stays_req soc_v got=%b want=1", tag, soc_v); end
    end
    eoc_v = 2'b00;
    @(negedge clock);
    checks++;
    if (soc_v !== 1'b0) begin errors++; $display("FAIL %s wait_soc_v got=%b want=0", tag, soc_v); end
    repeat ($urandom_range(0, 2)) @(negedge clock);
    if (stag) begin
      eoc_v = 2'b01;
      @(negedge clock);
      checks++;
      if (pos !== old || soc_v !== 1'b0) begin
        errors++; $display("FAIL %s partial_stays_wait pos=%h soc_v=%b want pos=%h soc_v=0", tag, pos, soc_v, old);
      end
    end
    v     = {vy, vx};
    eoc_v = 2'b11;
    @(negedge clock);
    checks++;
    if (pos !== old || eoc_p !== 1'b0) begin
      errors++; $display("FAIL %s pre_update pos=%h eoc_p=%b want pos=%h eoc_p=0", tag, pos, eoc_p, old);
    end
    @(negedge clock);
    checks++;
    if (pos !== {ey, ex} || eoc_p !== 1'b0) begin
      errors++; $display("FAIL %s update pos=%h eoc_p=%b want pos=%h eoc_p=0", tag, pos, eoc_p, {ey, ex});
    end
    v = 8'($urandom);
    @(negedge clock);
    checks++;
    if (eoc_p !== 1'b1 || pos !== {ey, ex}) begin
      errors++; $display("FAIL %s done pos=%h eoc_p=%b want pos=%h eoc_p=1", tag, pos, eoc_p, {ey, ex});
    end
`ifdef MOTION_OVF_FLAG_EN
    checks++;
    if (ovf !== om) begin errors++; $display("FAIL %s ovf got=%b want=%b", tag, ovf, om); end
`endif
    pm[0] = ex;
    pm[1] = ey;
  endtask

  task automatic set_positions(input logic [7:0] tx, input logic [7:0] ty);
    int dx, dy;
    for (int k = 0; k < 40; k++) begin
      dx = int'($signed(tx)) - int'($signed(pm[0]));
      dy = int'($signed(ty)) - int'($signed(pm[1]));
      if (dx == 0 && dy == 0) break;
      dx = (dx > 7) ? 7 : ((dx < -8) ? -8 : dx);
      dy = (dy > 7) ? 7 : ((dy < -8) ? -8 : dy);
      run_update(4'(dx), 4'(dy), 2'b00, 1'b0, "setup");
    end
  endtask

  task automatic test_reset();
    int n;
    do_reset();
    checks++;
    if (eoc_p !== 1'b1 || soc_v !== 1'b0 || pos !== 16'h0000) begin
      errors++; $display("FAIL reset_state eoc_p=%b soc_v=%b pos=%h want 1 0 0000", eoc_p, soc_v, pos);
    end
    run_update(4'h3, 4'h5, 2'b00, 1'b0, "pre_reset");
    mode  = 2'b00;
    soc_p = 1'b1;
    @(negedge clock);
    soc_p = 1'b0;
    n = 0;
    while (soc_v !== 1'b1 && n < 20) begin @(negedge clock); n++; end
    eoc_v = 2'b00;
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (eoc_p !== 1'b1 || soc_v !== 1'b0 || pos !== 16'h0000) begin
      errors++; $display("FAIL reset_mid_wait eoc_p=%b soc_v=%b pos=%h want 1 0 0000", eoc_p, soc_v, pos);
    end
    @(negedge clock);
    reset = 1'b0;
    eoc_v = 2'b11;
    pm[0] = 8'h00;
    pm[1] = 8'h00;
    om    = 2'b00;
    run_update(4'h2, 4'hF, 2'b00, 1'b0, "after_reset");
  endtask

  task automatic test_basic();
    do_reset();
    run_update(4'h3, 4'hE, 2'b00, 1'b0, "basic");
    checks++;
    if (pos !== 16'hFE03) begin errors++; $display("FAIL basic_const pos=%h want=fe03", pos); end
  endtask

  task automatic test_hold();
    do_reset();
    set_positions(8'h7E, 8'h10);
    run_update(4'h5, 4'h1, 2'b00, 1'b0, "hold");
    checks++;
    if (pos !== 16'h117E) begin errors++; $display("FAIL hold_const pos=%h want=117e", pos); end
  endtask

  task automatic test_sat();
    do_reset();
    set_positions(8'h7E, 8'h82);
    run_update(4'h5, 4'h8, 2'b01, 1'b0, "sat");
    checks++;
    if (pos !== 16'h807F) begin errors++; $display("FAIL sat_const pos=%h want=807f", pos); end
  endtask

  task automatic test_wrap_clear();
    do_reset();
    set_positions(8'h7E, 8'h00);
    run_update(4'h5, 4'h0, 2'b10, 1'b0, "wrap");
    checks++;
    if (pos !== 16'h0083) begin errors++; $display("FAIL wrap_const pos=%h want=0083", pos); end
    run_update(4'h0, 4'h0, 2'b11, 1'b0, "clear");
    checks++;
    if (pos !== 16'h0083) begin errors++; $display("FAIL clear_pos pos=%h want=0083", pos); end
  endtask

  task automatic test_staggered();
    for (int k = 0; k < 4; k++)
      run_update(4'($urandom), 4'($urandom), 2'($urandom), 1'b1, "stagger");
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 30; k++)
      run_update(4'($urandom), 4'($urandom), 2'($urandom), 1'($urandom), "random");
  endtask

  initial begin
    reset = 1'b1;
    v     = 8'h00;
    eoc_v = 2'b11;
    mode  = 2'b00;
    soc_p = 1'b0;
    pm[0] = 8'h00;
    pm[1] = 8'h00;
    om    = 2'b00;
    test_reset();
    test_basic();
    test_hold();
    test_sat();
    test_wrap_clear();
    test_staggered();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
